// File: rtl/a3_pkg.sv
// Shared constants and types for the instruction fetch stage.
package a3_pkg;

  localparam logic [7:0] CTL_NOP       = 8'h00;
  localparam logic [7:0] CTL_READ_ADDR = 8'h02;

  localparam int ADDR_WIDTH  = 64;
  localparam int QUEUE_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the PC control pair, byte-wide memory bus and decoder handshake.
interface fetch_unit_if;
  import a3_pkg::*;

  logic [7:0]            ctl_op_in;
  logic [ADDR_WIDTH-1:0] ctl_data_in;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic                  mem_rd_out;
  logic [7:0]            mem_data_in;
  logic                  mem_ack_in;
  logic [31:0]           instr_out;
  logic [ADDR_WIDTH-1:0] instr_addr_out;
  logic                  instr_valid_out;
  logic                  instr_ready_in;
  logic [15:0]           drop_count_out;

  modport slave (
    input  ctl_op_in, ctl_data_in, mem_data_in, mem_ack_in, instr_ready_in,
    output mem_addr_out, mem_rd_out, instr_out, instr_addr_out,
           instr_valid_out, drop_count_out
  );

  modport master (
    output ctl_op_in, ctl_data_in, mem_data_in, mem_ack_in, instr_ready_in,
    input  mem_addr_out, mem_rd_out, instr_out, instr_addr_out,
           instr_valid_out, drop_count_out
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO of fetch addresses; a push is still taken when full if a pop lands on the same edge.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [PW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == (PW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_data   = r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: queues PC addresses, reads four bytes each and presents little-endian words to the decoder.
module fetch_unit
  import a3_pkg::*;
#(
  parameter int QUEUE_DEPTH = a3_pkg::QUEUE_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  fetch_state_t          r_state, w_nextState;
  logic [ADDR_WIDTH-1:0] r_base, w_nextBase;
  logic [1:0]            r_idx, w_nextIdx, w_idxInc;
  logic [ADDR_WIDTH-1:0] r_memAddr, w_nextMemAddr;
  logic                  r_memRd, w_nextMemRd;
  logic [31:0]           r_instr, w_nextInstr;
  logic [ADDR_WIDTH-1:0] r_instrAddr, w_nextInstrAddr;
  logic                  r_valid, w_nextValid;
  logic [15:0]           r_dropCount;

  logic                  w_push, w_pop, w_full, w_empty;
  logic [ADDR_WIDTH-1:0] w_headAddr;

  assign w_push   = (bus.ctl_op_in == CTL_READ_ADDR);
  assign w_pop    = (r_state == IDLE) && !w_empty;
  assign w_idxInc = r_idx + 2'd1;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.ctl_data_in),
    .o_data  (w_headAddr),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_nextState     = r_state;
    w_nextBase      = r_base;
    w_nextIdx       = r_idx;
    w_nextMemAddr   = r_memAddr;
    w_nextMemRd     = r_memRd;
    w_nextInstr     = r_instr;
    w_nextInstrAddr = r_instrAddr;
    w_nextValid     = r_valid;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_nextState   = READ;
          w_nextBase    = w_headAddr;
          w_nextIdx     = 2'd0;
          w_nextMemAddr = w_headAddr;
          w_nextMemRd   = 1'b1;
          w_nextInstr   = '0;
        end
      end
      READ: begin
        if (bus.mem_ack_in) begin
          w_nextInstr[8*r_idx +: 8] = bus.mem_data_in;
          if (r_idx == 2'd3) begin
            w_nextState     = HOLD;
            w_nextMemRd     = 1'b0;
            w_nextValid     = 1'b1;
            w_nextInstrAddr = r_base;
          end else begin
            w_nextIdx     = w_idxInc;
            w_nextMemAddr = r_base + ADDR_WIDTH'(w_idxInc);
          end
        end
      end
      HOLD: begin
        if (bus.instr_ready_in) begin
          w_nextState = IDLE;
          w_nextValid = 1'b0;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_idx       <= '0;
      r_memAddr   <= '0;
      r_memRd     <= 1'b0;
      r_instr     <= '0;
      r_instrAddr <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_base      <= w_nextBase;
      r_idx       <= w_nextIdx;
      r_memAddr   <= w_nextMemAddr;
      r_memRd     <= w_nextMemRd;
      r_instr     <= w_nextInstr;
      r_instrAddr <= w_nextInstrAddr;
      r_valid     <= w_nextValid;
    end
  end

  // A request is lost only when the queue is full and nothing leaves on this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dropCount <= '0;
    end else if (w_push && w_full && !w_pop && (r_dropCount != 16'hFFFF)) begin
      r_dropCount <= r_dropCount + 16'd1;
    end
  end

  assign bus.mem_addr_out    = r_memAddr;
  assign bus.mem_rd_out      = r_memRd;
  assign bus.instr_out       = r_instr;
  assign bus.instr_addr_out  = r_instrAddr;
  assign bus.instr_valid_out = r_valid;
  assign bus.drop_count_out  = r_dropCount;

endmodule
